// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator with a 2-entry
// skid buffer (output register + skid register), valid/ready on both sides.
//   clk, rst_n (async, active-low), flush (sync drop of all buffered entries)
//   in_valid/in_ready/in_instr/in_sel/in_tag : instruction side
//   out_valid/out_ready/out_imm/out_tag/out_err : execute side
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [2:0] {
    SEL_I     = 3'b000,
    SEL_S     = 3'b001,
    SEL_B     = 3'b010,
    SEL_J     = 3'b011,
    SEL_U     = 3'b100,
    SEL_SHAMT = 3'b101,
    SEL_ZIMM  = 3'b110,
    SEL_RSVD  = 3'b111
  } sel_e;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             unused_opcode;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             out_err_q,   out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;

  logic             in_fire;
  logic             out_free;

  assign unused_opcode = ^in_instr[6:0];

  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (sel_e'(in_sel))
      SEL_I: begin
        dec_imm        = {XLEN{in_instr[31]}};
        dec_imm[11:0]  = in_instr[31:20];
      end
      SEL_S: begin
        dec_imm        = {XLEN{in_instr[31]}};
        dec_imm[11:0]  = {in_instr[31:25], in_instr[11:7]};
      end
      SEL_B: begin
        dec_imm        = {XLEN{in_instr[31]}};
        dec_imm[12:0]  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      SEL_J: begin
        dec_imm        = {XLEN{in_instr[31]}};
        dec_imm[20:0]  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      SEL_U: begin
        dec_imm        = {XLEN{in_instr[31]}};
        dec_imm[31:0]  = {in_instr[31:12], 12'b0};
      end
      SEL_SHAMT: begin
        if (XLEN == 64) dec_imm[5:0] = in_instr[25:20];
        else            dec_imm[4:0] = in_instr[24:20];
      end
      SEL_ZIMM: dec_imm[4:0] = in_instr[19:15];
      default:  dec_err = 1'b1;
    endcase
  end

  assign in_fire  = in_valid & ~skid_valid_q;
  // Output register can take a new entry when empty or draining this cycle.
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no new input competes here.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d  = 1'b1;
        out_imm_d    = dec_imm;
        out_tag_d    = in_tag;
        out_err_d    = dec_err;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_err_d   = dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference decoder: builds the signed immediate value from its bit fields
  // and sign-extends arithmetically, then truncates to the datapath width.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [2:0] sel,
                                   input logic [7:0] tag, input int xl);
    exp_t e;
    longint v;
    logic signed [11:0] f12;
    logic signed [12:0] f13;
    logic signed [20:0] f21;
    logic signed [31:0] f32;
    e.err = 1'b0;
    case (sel)
      3'd0: begin f12 = ins[31:20]; v = longint'(f12); end
      3'd1: begin f12 = {ins[31:25], ins[11:7]}; v = longint'(f12); end
      3'd2: begin f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = longint'(f13); end
      3'd3: begin f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = longint'(f21); end
      3'd4: begin f32 = ins; v = longint'(f32) & ~longint'(64'hFFF); end
      3'd5: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: v = longint'(ins[19:15]);
      default: begin v = 0; e.err = 1'b1; end
    endcase
    if (xl == 32) v = v & longint'(64'hFFFF_FFFF);
    e.imm = v;
    e.tag = tag;
    return e;
  endfunction

  // Scoreboard monitor: samples 1 time unit after each falling edge, i.e.
  // with all inputs for the coming rising edge settled.
  logic        hold;
  logic        hold_flush;
  logic [31:0] hold_imm;
  logic [7:0]  hold_tag;
  logic        hold_err;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      q32.delete();
      q64.delete();
      hold = 1'b0;
    end else begin
      if (hold && !hold_flush) begin
        chk("stable_valid", {63'b0, out_valid32}, 64'd1);
        chk("stable_imm",   {32'b0, out_imm32},   {32'b0, hold_imm});
        chk("stable_tag",   {56'b0, out_tag32},   {56'b0, hold_tag});
        chk("stable_err",   {63'b0, out_err32},   {63'b0, hold_err});
      end
      if (out_valid32 && out_ready) begin
        if (q32.size() == 0) begin
          checks++;
          $display("FAIL spurious_out32: got tag 0x%0h expected no output", out_tag32);
        end else begin
          e = q32.pop_front();
          chk("sb_imm32", {32'b0, out_imm32}, e.imm);
          chk("sb_tag32", {56'b0, out_tag32}, {56'b0, e.tag});
          chk("sb_err32", {63'b0, out_err32}, {63'b0, e.err});
        end
      end
      if (out_valid64 && out_ready) begin
        if (q64.size() == 0) begin
          checks++;
          $display("FAIL spurious_out64: got tag 0x%0h expected no output", out_tag64);
        end else begin
          e = q64.pop_front();
          chk("sb_imm64", out_imm64, e.imm);
          chk("sb_tag64", {56'b0, out_tag64}, {56'b0, e.tag});
          chk("sb_err64", {63'b0, out_err64}, {63'b0, e.err});
        end
      end
      hold       = out_valid32 && !out_ready;
      hold_flush = flush;
      hold_imm   = out_imm32;
      hold_tag   = out_tag32;
      hold_err   = out_err32;
      if (flush) begin
        q32.delete();
        q64.delete();
      end else if (in_valid && in_ready32) begin
        q32.push_back(ref_dec(in_instr, in_sel, in_tag, 32));
        q64.push_back(ref_dec(in_instr, in_sel, in_tag, 64));
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] tag);
    int unsigned n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_sel = sel; in_tag = tag;
    while (!in_ready32 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready32) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for tag 0x%0h", tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [31:0] ins, input logic [2:0] sel,
                          input logic [63:0] e32, input logic [63:0] e64, input logic eerr);
    out_ready = 1'b1;
    send(ins, sel, 8'hA5);
    #2;
    chk({nm, "_valid"}, {62'b0, out_valid64, out_valid32}, 64'd3);
    chk({nm, "_imm32"}, {32'b0, out_imm32}, e32);
    chk({nm, "_imm64"}, out_imm64, e64);
    chk({nm, "_err"},   {62'b0, out_err64, out_err32}, {62'b0, eerr, eerr});
  endtask

  task automatic run_random(input int unsigned n, input bit full);
    int unsigned sent = 0;
    int unsigned cyc = 0;
    bit will_accept = 1'b0;
    in_valid = 1'b0;
    while (sent < n && cyc < n * 8) begin
      @(negedge clk);
      cyc++;
      if (will_accept) begin
        sent++;
        in_valid = 1'b0;
      end
      out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
      if (!in_valid && sent < n && (full || $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_instr = $urandom;
        in_sel   = 3'($urandom_range(0, 7));
        in_tag   = 8'($urandom);
      end
      will_accept = in_valid && in_ready32;
    end
    chk("random_sent", 64'(sent), 64'(n));
    if (full) chk("throughput_cycles", 64'(cyc), 64'(n + 1));
  endtask

  task automatic drain;
    int unsigned n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q32.size() != 0 || out_valid32) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_q32_empty", 64'(q32.size()), 64'd0);
    chk("drain_q64_empty", 64'(q64.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_sel = '0; in_tag = '0;
    hold = 1'b0; hold_flush = 1'b0;
    #2;
    chk("rst_out_valid", {62'b0, out_valid64, out_valid32}, 64'd0);
    chk("rst_in_ready",  {62'b0, in_ready64, in_ready32},   64'd3);
    chk("rst_out_imm32", {32'b0, out_imm32}, 64'd0);
    chk("rst_out_imm64", out_imm64, 64'd0);
    chk("rst_out_tag",   {48'b0, out_tag64, out_tag32}, 64'd0);
    chk("rst_out_err",   {62'b0, out_err64, out_err32}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    directed("fmt_i",   32'hFFF00093, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    directed("fmt_s",   32'h00112623, 3'd1, 64'h0000_000C, 64'h0000_0000_0000_000C, 1'b0);
    directed("fmt_b",   32'hFE000EE3, 3'd2, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    directed("fmt_j",   32'hFF9FF06F, 3'd3, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    directed("fmt_u",   32'h80000037, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    directed("shamt63", 32'h03F09093, 3'd5, 64'd31, 64'd63, 1'b0);
    directed("shamt31", 32'h01F09093, 3'd5, 64'd31, 64'd31, 1'b0);
    directed("zimm",    32'h000F8073, 3'd6, 64'd31, 64'd31, 1'b0);
    directed("rsvd",    32'hFFFFFFFF, 3'd7, 64'd0, 64'd0, 1'b1);
    drain();

    // Backpressure: tag 1 in output register, tag 2 in skid, tag 3 waits.
    out_ready = 1'b0;
    send(32'h00100093, 3'd0, 8'd1);
    send(32'h00200093, 3'd0, 8'd2);
    #1;
    chk("bp_in_ready_low", {63'b0, in_ready32}, 64'd0);
    chk("bp_out_tag1",     {56'b0, out_tag32},  64'd1);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00300093; in_sel = 3'd0; in_tag = 8'd3;
    repeat (2) @(negedge clk);
    chk("bp_still_blocked", {63'b0, in_ready32}, 64'd0);
    out_ready = 1'b1;
    begin
      int unsigned n = 0;
      while (!in_ready32 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("bp_ready_return", {63'b0, in_ready32}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Flush while the skid is full, with tag 4 offered in the flush cycle.
    out_ready = 1'b0;
    send(32'h00500093, 3'd0, 8'd5);
    send(32'h00600093, 3'd0, 8'd6);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00400093; in_sel = 3'd0; in_tag = 8'd4;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {62'b0, out_valid64, out_valid32}, 64'd0);
    chk("flush_in_ready",  {62'b0, in_ready64, in_ready32},   64'd3);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("flush_no_tag4", {63'b0, out_valid32}, 64'd0);

    // Asynchronous reset with the skid full.
    out_ready = 1'b0;
    send(32'h00700093, 3'd0, 8'd7);
    send(32'h00800093, 3'd0, 8'd8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {62'b0, out_valid64, out_valid32}, 64'd0);
    chk("async_rst_in_ready",  {62'b0, in_ready64, in_ready32},   64'd3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {63'b0, out_valid32}, 64'd0);

    run_random(10000, 1'b0);
    drain();
    run_random(2000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
